// File: rtl/ws2812_pkg.sv
// ---------------------------------------------------------------------------
// ws2812_pkg
//   Shared WS2812 line timing at 50 MHz and the receiver state encoding.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ws2812_pkg;

  localparam int unsigned c_clk_hz       = 50_000_000;
  localparam int unsigned c_t0h_cycles   = 20;    // 0.40 us
  localparam int unsigned c_t1h_cycles   = 40;    // 0.80 us
  localparam int unsigned c_bit_cycles   = 62;    // 1.25 us, rounded down
  localparam int unsigned c_reset_cycles = 2500;  // 50 us latch gap
  localparam int unsigned c_cnt_w        = 12;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_IDLE = 2'd1,
    S_HIGH = 2'd2,
    S_LOW  = 2'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/ws2812_sync.sv
// ---------------------------------------------------------------------------
// ws2812_sync
//   Two-flop synchronizer for the WS2812 line plus edge strobes.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ws2812_sync
  import ws2812_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_din,
  output logic o_din_s,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_dly  <= 1'b0;
    end else begin
      r_meta <= i_din;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_din_s = r_sync;
  assign o_rise  = r_sync & ~r_dly;
  assign o_fall  = ~r_sync & r_dly;

endmodule

`default_nettype wire

// File: rtl/ws2812_rx.sv
// ---------------------------------------------------------------------------
// ws2812_rx
//   WS2812 serial line receiver: pulse-width bit decode, 24-bit pixel
//   assembly, frame-end detection and protocol error reporting.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int unsigned T_MIN_HIGH = 8,
  parameter int unsigned T_THRESH   = 30,
  parameter int unsigned T_MAX_HIGH = 75,
  parameter int unsigned T_RESET    = c_reset_cycles
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  output logic        pixel_valid,
  output logic [23:0] pixel_data,
  output logic        frame_done,
  output logic [9:0]  pixel_count,
  output logic        err
);

  localparam logic [c_cnt_w-1:0] c_min_high = c_cnt_w'(T_MIN_HIGH);
  localparam logic [c_cnt_w-1:0] c_thresh   = c_cnt_w'(T_THRESH);
  localparam logic [c_cnt_w-1:0] c_max_high = c_cnt_w'(T_MAX_HIGH);
  localparam logic [c_cnt_w-1:0] c_reset    = c_cnt_w'(T_RESET);

  logic w_din_s, w_rise, w_fall;

  ws2812_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_din   (din),
    .o_din_s (w_din_s),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  rx_state_t          r_state, w_state;
  logic [c_cnt_w-1:0] r_high_cnt, w_high_cnt, w_high_inc;
  logic [c_cnt_w-1:0] r_low_cnt, w_low_cnt, w_low_inc;
  logic [22:0]        r_shift, w_shift;
  logic [4:0]         r_bit_cnt, w_bit_cnt;
  logic [23:0]        r_pixel, w_pixel;
  logic [9:0]         r_pix_cnt, w_pix_cnt;
  logic               r_valid, w_valid, r_done, w_done, r_err, w_err;
  logic               w_bit;

  assign w_high_inc = (r_high_cnt < c_max_high) ? r_high_cnt + 12'd1 : r_high_cnt;
  assign w_low_inc  = (r_low_cnt < c_reset) ? r_low_cnt + 12'd1 : r_low_cnt;
  assign w_bit      = (r_high_cnt >= c_thresh);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_SYNC;
      r_high_cnt <= '0;
      r_low_cnt  <= '0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_pixel    <= '0;
      r_pix_cnt  <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_high_cnt <= w_high_cnt;
      r_low_cnt  <= w_low_cnt;
      r_shift    <= w_shift;
      r_bit_cnt  <= w_bit_cnt;
      r_pixel    <= w_pixel;
      r_pix_cnt  <= w_pix_cnt;
      r_valid    <= w_valid;
      r_done     <= w_done;
      r_err      <= w_err;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_high_cnt = r_high_cnt;
    w_low_cnt  = r_low_cnt;
    w_shift    = r_shift;
    w_bit_cnt  = r_bit_cnt;
    w_pixel    = r_pixel;
    w_pix_cnt  = r_done ? 10'd0 : r_pix_cnt;
    w_valid    = 1'b0;
    w_done     = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      S_SYNC: begin
        if (w_din_s) begin
          w_low_cnt = '0;
        end else begin
          w_low_cnt = w_low_inc;
          if (w_low_inc == c_reset) w_state = S_IDLE;
        end
      end
      S_IDLE: begin
        if (w_rise) begin
          w_state    = S_HIGH;
          w_high_cnt = 12'd1;
        end
      end
      S_HIGH: begin
        if (w_fall) begin
          if (r_high_cnt < c_min_high) begin
            // Runt pulse abandons the frame; this falling cycle is the first low.
            w_err     = 1'b1;
            w_state   = S_SYNC;
            w_low_cnt = 12'd1;
            w_bit_cnt = '0;
            w_pix_cnt = '0;
          end else begin
            w_shift   = {r_shift[21:0], w_bit};
            w_state   = S_LOW;
            w_low_cnt = 12'd1;
            if (r_bit_cnt == 5'd23) begin
              w_bit_cnt = '0;
              w_pixel   = {r_shift, w_bit};
              w_valid   = 1'b1;
              w_pix_cnt = (r_pix_cnt == 10'd1023) ? r_pix_cnt : r_pix_cnt + 10'd1;
            end else begin
              w_bit_cnt = r_bit_cnt + 5'd1;
            end
          end
        end else begin
          w_high_cnt = w_high_inc;
          if (w_high_inc == c_max_high) begin
            w_err     = 1'b1;
            w_state   = S_SYNC;
            w_low_cnt = '0;
            w_bit_cnt = '0;
            w_pix_cnt = '0;
          end
        end
      end
      S_LOW: begin
        if (w_rise) begin
          w_state    = S_HIGH;
          w_high_cnt = 12'd1;
        end else begin
          w_low_cnt = w_low_inc;
          if (w_low_inc == c_reset) begin
            w_done    = 1'b1;
            w_err     = (r_bit_cnt != 5'd0);
            w_bit_cnt = '0;
            w_state   = S_IDLE;
          end
        end
      end
      default: w_state = S_SYNC;
    endcase
  end

  assign pixel_valid = r_valid;
  assign pixel_data  = r_pixel;
  assign frame_done  = r_done;
  assign pixel_count = r_pix_cnt;
  assign err         = r_err;

endmodule

`default_nettype wire
